// File: rtl/piece_move_if.sv
// Request/collision/position bundle between the input-timer logic, the collision checker and
// piece_move_controller. The controller takes the slave modport.
interface piece_move_if #(
   parameter int unsigned XW = 4,
   parameter int unsigned YW = 5
);
   logic          spawn_req;
   logic          gravity_tick;
   logic          left_req;
   logic          right_req;
   logic          down_req;
   logic          left_collision;
   logic          right_collision;
   logic          down_collision;
   logic [XW-1:0] piece_x;
   logic [YW-1:0] piece_y;
   logic          no_piece;
   logic          lock_pulse;
   logic          top_out;

   modport master (
      output spawn_req, gravity_tick, left_req, right_req, down_req,
      output left_collision, right_collision, down_collision,
      input  piece_x, piece_y, no_piece, lock_pulse, top_out
   );

   modport slave (
      input  spawn_req, gravity_tick, left_req, right_req, down_req,
      input  left_collision, right_collision, down_collision,
      output piece_x, piece_y, no_piece, lock_pulse, top_out
   );
endinterface

// File: rtl/piece_move_controller.sv
// Falling-piece sequencer: spawn, gravity/player moves, lock delay and top-out detection.
// Optional macro PIECE_MOVE_LOCK_RESET_EN: successful left/right moves also clear the lock delay.
module piece_move_controller #(
   parameter int unsigned BOARD_WIDTH  = 10,
   parameter int unsigned BOARD_HEIGHT = 20,
   parameter int unsigned SPAWN_X      = 3,
   parameter int unsigned LOCK_TICKS   = 2
) (
   input logic         clk,
   input logic         reset_n,
   piece_move_if.slave bus
);
   localparam int unsigned XW = $clog2(BOARD_WIDTH);
   localparam int unsigned YW = $clog2(BOARD_HEIGHT);
   localparam logic [XW-1:0] XMax      = XW'(BOARD_WIDTH - 1);
   localparam logic [YW-1:0] YMax      = YW'(BOARD_HEIGHT - 1);
   localparam logic [XW-1:0] XSpawn    = XW'(SPAWN_X);
   localparam logic [3:0]    LockTicks = 4'(LOCK_TICKS);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StSpawn  = 3'd1;
   localparam logic [2:0] StSettle = 3'd2;
   localparam logic [2:0] StActive = 3'd3;
   localparam logic [2:0] StLock   = 3'd4;
   localparam logic [2:0] StDead   = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          no_piece_q, no_piece_d;
   logic          top_out_q, top_out_d;
   logic [3:0]    lock_cnt_q, lock_cnt_d;
   logic          pend_down_q, pend_down_d;
   logic          pend_left_q, pend_left_d;
   logic          pend_right_q, pend_right_d;
   logic          want_down, want_left, want_right;
   logic [3:0]    lock_cnt_inc;

   // Requests arriving this cycle are visible immediately so an idle ACTIVE moves on the next edge.
   assign want_down    = pend_down_q | bus.gravity_tick | bus.down_req;
   assign want_left    = pend_left_q | bus.left_req;
   assign want_right   = pend_right_q | bus.right_req;
   assign lock_cnt_inc = lock_cnt_q + 4'd1;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      no_piece_d   = no_piece_q;
      top_out_d    = top_out_q;
      lock_cnt_d   = lock_cnt_q;
      pend_down_d  = want_down;
      pend_left_d  = want_left;
      pend_right_d = want_right;
      case (state_q)
         StIdle: begin
            pend_down_d  = 1'b0;
            pend_left_d  = 1'b0;
            pend_right_d = 1'b0;
            no_piece_d   = 1'b1;
            if (bus.spawn_req) state_d = StSpawn;
         end
         StSpawn: begin
            x_d        = XSpawn;
            y_d        = '0;
            no_piece_d = 1'b0;
            lock_cnt_d = '0;
            state_d    = StSettle;
         end
         StSettle: state_d = StActive;
         StActive: begin
            if (want_down) begin
               pend_down_d = 1'b0;
               if (!bus.down_collision && (y_q < YMax)) begin
                  y_d        = y_q + YW'(1);
                  lock_cnt_d = '0;
                  state_d    = StSettle;
               end else begin
                  lock_cnt_d = lock_cnt_inc;
                  if (lock_cnt_inc == LockTicks) state_d = StLock;
               end
            end else if (want_left) begin
               pend_left_d = 1'b0;
               if (!bus.left_collision && (x_q != '0)) begin
                  x_d     = x_q - XW'(1);
                  state_d = StSettle;
`ifdef PIECE_MOVE_LOCK_RESET_EN
                  lock_cnt_d = '0;
`endif
               end
            end else if (want_right) begin
               pend_right_d = 1'b0;
               if (!bus.right_collision && (x_q < XMax)) begin
                  x_d     = x_q + XW'(1);
                  state_d = StSettle;
`ifdef PIECE_MOVE_LOCK_RESET_EN
                  lock_cnt_d = '0;
`endif
               end
            end
         end
         StLock: begin
            pend_down_d  = 1'b0;
            pend_left_d  = 1'b0;
            pend_right_d = 1'b0;
            no_piece_d   = 1'b1;
            lock_cnt_d   = '0;
            if (y_q == '0) begin
               top_out_d = 1'b1;
               state_d   = StDead;
            end else begin
               state_d = StIdle;
            end
         end
         StDead: begin
            pend_down_d  = 1'b0;
            pend_left_d  = 1'b0;
            pend_right_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         x_q          <= '0;
         y_q          <= '0;
         no_piece_q   <= 1'b1;
         top_out_q    <= 1'b0;
         lock_cnt_q   <= '0;
         pend_down_q  <= 1'b0;
         pend_left_q  <= 1'b0;
         pend_right_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         no_piece_q   <= no_piece_d;
         top_out_q    <= top_out_d;
         lock_cnt_q   <= lock_cnt_d;
         pend_down_q  <= pend_down_d;
         pend_left_q  <= pend_left_d;
         pend_right_q <= pend_right_d;
      end
   end

   assign bus.piece_x    = x_q;
   assign bus.piece_y    = y_q;
   assign bus.no_piece   = no_piece_q;
   assign bus.lock_pulse = (state_q == StLock);
   assign bus.top_out    = top_out_q;
endmodule

// File: tb/tb_piece_move_controller.sv
// Bench for piece_move_controller: directed scenarios with fixed expectations plus randomized
// traffic compared against a cycle-level game model.
module tb_piece_move_controller;
   localparam int W = 10, H = 20, SX = 3, LT = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   passed = 0, total = 0;

   piece_move_if #(.XW(4), .YW(5)) bus ();

   piece_move_controller #(
      .BOARD_WIDTH(W), .BOARD_HEIGHT(H), .SPAWN_X(SX), .LOCK_TICKS(LT)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Game model: position, lock counter, queued requests and a settle countdown.
   int mx, my, mlock, wait_n;
   bit mnp, mtop, spawn_in, locking, pd, pl, pr;

   task automatic model_step();
      bit d, l, r;
      if (!reset_n) begin
         mx = 0; my = 0; mlock = 0; wait_n = 0;
         mnp = 1; mtop = 0; spawn_in = 0; locking = 0; pd = 0; pl = 0; pr = 0;
      end else if (mtop) begin
         // game over: frozen until reset
      end else if (locking) begin
         locking = 0; mnp = 1; mlock = 0; pd = 0; pl = 0; pr = 0;
         if (my == 0) mtop = 1;
      end else if (spawn_in) begin
         spawn_in = 0; mx = SX; my = 0; mnp = 0; mlock = 0; wait_n = 1;
         pd = pd | bus.gravity_tick | bus.down_req;
         pl = pl | bus.left_req;
         pr = pr | bus.right_req;
      end else if (mnp) begin
         pd = 0; pl = 0; pr = 0;
         if (bus.spawn_req) spawn_in = 1;
      end else begin
         d = pd | bus.gravity_tick | bus.down_req;
         l = pl | bus.left_req;
         r = pr | bus.right_req;
         if (wait_n > 0) begin
            wait_n = wait_n - 1;
         end else if (d) begin
            d = 0;
            if (!bus.down_collision && my < H - 1) begin
               my = my + 1; mlock = 0; wait_n = 1;
            end else begin
               mlock = mlock + 1;
               if (mlock == LT) locking = 1;
            end
         end else if (l) begin
            l = 0;
            if (!bus.left_collision && mx > 0) begin
               mx = mx - 1; wait_n = 1;
`ifdef PIECE_MOVE_LOCK_RESET_EN
               mlock = 0;
`endif
            end
         end else if (r) begin
            r = 0;
            if (!bus.right_collision && mx < W - 1) begin
               mx = mx + 1; wait_n = 1;
`ifdef PIECE_MOVE_LOCK_RESET_EN
               mlock = 0;
`endif
            end
         end
         pd = d; pl = l; pr = r;
      end
   endtask

   function automatic logic [11:0] exp_vec();
      return {4'(mx), 5'(my), mnp, locking, mtop};
   endfunction

   function automatic logic [11:0] obs_vec();
      return {bus.piece_x, bus.piece_y, bus.no_piece, bus.lock_pulse, bus.top_out};
   endfunction

   // One clock: drive inputs, take the edge, advance the model, return at the falling edge.
   task automatic tick(input bit s, g, l, r, dn, lc, rc, dc, rn);
      bus.spawn_req = s; bus.gravity_tick = g; bus.left_req = l; bus.right_req = r;
      bus.down_req = dn; bus.left_collision = lc; bus.right_collision = rc;
      bus.down_collision = dc; reset_n = rn;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic do_reset();
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_spawn();
      tick(1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      idle();
   endtask

   task automatic test_reset();
      tick(1, 1, 1, 1, 1, 0, 0, 0, 0);
      total++;
      if (obs_vec() !== 12'h004)
         $display("FAIL reset_state: got %h want 004", obs_vec());
      else passed++;
   endtask

   task automatic test_spawn();
      do_reset();
      tick(1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++;
      if (bus.no_piece !== 1'b1) $display("FAIL spawn_idle_edge: no_piece=%b want 1", bus.no_piece);
      else passed++;
      idle();
      idle();
      total++;
      if (bus.piece_x !== 4'd3 || bus.piece_y !== 5'd0 || bus.no_piece !== 1'b0 ||
          bus.lock_pulse !== 1'b0)
         $display("FAIL spawn_pos: x=%0d y=%0d np=%b lp=%b want x=3 y=0 np=0 lp=0",
                  bus.piece_x, bus.piece_y, bus.no_piece, bus.lock_pulse);
      else passed++;
      // ACTIVE now: a single right request moves on the very next edge
      tick(0, 0, 0, 1, 0, 0, 0, 0, 1);
      total++;
      if (bus.piece_x !== 4'd4) $display("FAIL spawn_active_latency: x=%0d want 4", bus.piece_x);
      else passed++;
   endtask

   task automatic test_down_left();
      do_reset();
      do_spawn();
      tick(0, 1, 1, 0, 0, 0, 0, 0, 1);
      total++;
      if (bus.piece_y !== 5'd1 || bus.piece_x !== 4'd3)
         $display("FAIL dl_down_first: x=%0d y=%0d want x=3 y=1", bus.piece_x, bus.piece_y);
      else passed++;
      idle();
      total++;
      if (bus.piece_x !== 4'd3) $display("FAIL dl_settle: x=%0d want 3", bus.piece_x);
      else passed++;
      idle();
      total++;
      if (bus.piece_x !== 4'd2 || bus.piece_y !== 5'd1)
         $display("FAIL dl_left: x=%0d y=%0d want x=2 y=1", bus.piece_x, bus.piece_y);
      else passed++;
      repeat (3) idle();
      total++;
      if (bus.piece_x !== 4'd2 || bus.piece_y !== 5'd1)
         $display("FAIL dl_once: x=%0d y=%0d want x=2 y=1", bus.piece_x, bus.piece_y);
      else passed++;
   endtask

   task automatic test_lock();
      do_reset();
      do_spawn();
      repeat (5) begin
         tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
         idle();
      end
      tick(0, 1, 0, 0, 0, 0, 0, 1, 1);
      total++;
      if (bus.piece_y !== 5'd5 || bus.lock_pulse !== 1'b0)
         $display("FAIL lock_first_tick: y=%0d lp=%b want y=5 lp=0", bus.piece_y, bus.lock_pulse);
      else passed++;
      tick(0, 1, 0, 0, 0, 0, 0, 1, 1);
      total++;
      if (bus.lock_pulse !== 1'b1) $display("FAIL lock_pulse_high: lp=%b want 1", bus.lock_pulse);
      else passed++;
      idle();
      total++;
      if (bus.lock_pulse !== 1'b0 || bus.no_piece !== 1'b1 || bus.top_out !== 1'b0)
         $display("FAIL lock_after: lp=%b np=%b to=%b want 0 1 0",
                  bus.lock_pulse, bus.no_piece, bus.top_out);
      else passed++;
      do_spawn();
      total++;
      if (bus.no_piece !== 1'b0) $display("FAIL lock_back_idle: np=%b want 0", bus.no_piece);
      else passed++;
   endtask

   task automatic test_boundary();
      do_reset();
      do_spawn();
      repeat (3) begin
         tick(0, 0, 1, 0, 0, 0, 0, 0, 1);
         idle();
      end
      tick(0, 0, 1, 0, 0, 0, 0, 0, 1);
      idle();
      total++;
      if (bus.piece_x !== 4'd0) $display("FAIL bnd_left_sat: x=%0d want 0", bus.piece_x);
      else passed++;
      // dropped left must not shadow a fresh right request
      tick(0, 0, 0, 1, 0, 0, 0, 0, 1);
      total++;
      if (bus.piece_x !== 4'd1) $display("FAIL bnd_left_dropped: x=%0d want 1", bus.piece_x);
      else passed++;
      idle();
      repeat (9) begin
         tick(0, 0, 0, 1, 0, 0, 0, 0, 1);
         idle();
      end
      total++;
      if (bus.piece_x !== 4'd9) $display("FAIL bnd_right_sat: x=%0d want 9", bus.piece_x);
      else passed++;
      repeat (19) begin
         tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
         idle();
      end
      total++;
      if (bus.piece_y !== 5'd19) $display("FAIL bnd_reach_bottom: y=%0d want 19", bus.piece_y);
      else passed++;
      tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
      total++;
      if (bus.piece_y !== 5'd19 || bus.lock_pulse !== 1'b0)
         $display("FAIL bnd_bottom_sat: y=%0d lp=%b want 19 0", bus.piece_y, bus.lock_pulse);
      else passed++;
      tick(0, 0, 0, 0, 1, 0, 0, 0, 1);
      total++;
      if (bus.lock_pulse !== 1'b1) $display("FAIL bnd_bottom_lock: lp=%b want 1", bus.lock_pulse);
      else passed++;
   endtask

   task automatic test_top_out();
      do_reset();
      do_spawn();
      tick(0, 1, 0, 0, 0, 0, 0, 1, 1);
      tick(0, 1, 0, 0, 0, 0, 0, 1, 1);
      idle();
      total++;
      if (bus.top_out !== 1'b1 || bus.no_piece !== 1'b1)
         $display("FAIL top_set: to=%b np=%b want 1 1", bus.top_out, bus.no_piece);
      else passed++;
      tick(1, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (4) idle();
      total++;
      if (bus.top_out !== 1'b1 || bus.no_piece !== 1'b1 || bus.lock_pulse !== 1'b0)
         $display("FAIL top_sticky: to=%b np=%b lp=%b want 1 1 0",
                  bus.top_out, bus.no_piece, bus.lock_pulse);
      else passed++;
      do_reset();
      total++;
      if (bus.top_out !== 1'b0) $display("FAIL top_cleared: to=%b want 0", bus.top_out);
      else passed++;
   endtask

   task automatic test_lock_reset();
      do_reset();
      do_spawn();
      tick(0, 1, 0, 0, 0, 0, 0, 1, 1);
      tick(0, 0, 0, 1, 0, 0, 0, 0, 1);
      idle();
      tick(0, 1, 0, 0, 0, 0, 0, 1, 1);
      total++;
`ifdef PIECE_MOVE_LOCK_RESET_EN
      if (bus.lock_pulse !== 1'b0 || bus.piece_x !== 4'd4)
         $display("FAIL slide_postpone: lp=%b x=%0d want 0 4", bus.lock_pulse, bus.piece_x);
      else passed++;
      tick(0, 1, 0, 0, 0, 0, 0, 1, 1);
      total++;
      if (bus.lock_pulse !== 1'b1) $display("FAIL slide_lock: lp=%b want 1", bus.lock_pulse);
      else passed++;
`else
      if (bus.lock_pulse !== 1'b1 || bus.piece_x !== 4'd4)
         $display("FAIL slide_lock: lp=%b x=%0d want 1 4", bus.lock_pulse, bus.piece_x);
      else passed++;
`endif
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(4) == 0,
              $urandom_range(4) == 0, $urandom_range(6) == 0, $urandom_range(3) == 0,
              $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(199) != 0);
         total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL random_cyc%0d: got {x,y,np,lp,to}=%h want %h", i, obs_vec(), exp_vec());
         else passed++;
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_spawn();
      test_down_left();
      test_lock();
      test_boundary();
      test_top_out();
      test_lock_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
